// File: rtl/conv2d_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv2d_stream: streaming KxK signed convolution, 2-cycle result latency.   |
// | Optional CONV_RELU_EN clamps negative results to 0.       Revision: 1.0    |
// +----------------------------------------------------------------------------+
module conv2d_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int OUT_W  = 16,
  localparam int AW    = (K > 1) ? $clog2(K * K) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    coef_wr,
  input  logic [AW-1:0]           coef_addr,
  input  logic [COEF_W-1:0]       coef_din,
  input  logic                    in_st,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    busy
);

  localparam int NC      = K * K;
  localparam int XW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PROD_W  = DATA_W + 1 + COEF_W;
  localparam int SUM_W   = PROD_W + $clog2(NC);
  localparam int ACC_W   = (SUM_W > OUT_W) ? SUM_W : OUT_W + 1;
  localparam int LB_ROWS = (K > 1) ? K - 1 : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

`ifdef CONV_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic                      flush_q, flush_d;
  logic signed [COEF_W-1:0]  coef_q [NC];
  logic signed [COEF_W-1:0]  coef_d [NC];
  logic                      accept;

  logic [DATA_W-1:0]         lb_mem [LB_ROWS][IMG_W];
  logic [DATA_W-1:0]         col    [K];
  logic [DATA_W-1:0]         win_q  [K][K];
  logic [DATA_W-1:0]         win_d  [K][K];
  logic                      v0_q, v0_d, l0_q, l0_d;
  logic                      v1_q, l1_q;
  logic signed [PROD_W-1:0]  prod_q [NC];
  logic signed [PROD_W-1:0]  prod_d [NC];
  logic signed [ACC_W-1:0]   acc;
  logic signed [OUT_W-1:0]   dout_q, dout_d;
  logic                      out_valid_q, out_last_q;

  assign accept = (state_q == S_RUN) && in_valid;

  // Frame sequencing, raster counters and the frozen-while-busy kernel.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    flush_d = flush_q;
    v0_d    = 1'b0;
    l0_d    = 1'b0;
    for (int i = 0; i < NC; i++) coef_d[i] = coef_q[i];
    case (state_q)
      S_IDLE: begin
        if (coef_wr && (coef_addr < AW'(NC))) coef_d[coef_addr] = coef_din;
        if (in_st) begin
          state_d = S_RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          v0_d = (y_q >= YW'(K - 1)) && (x_q >= XW'(K - 1));
          l0_d = (y_q == YW'(IMG_H - 1)) && (x_q == XW'(IMG_W - 1));
          if (x_q == XW'(IMG_W - 1)) begin
            x_d = '0;
            if (y_q == YW'(IMG_H - 1)) begin
              y_d     = '0;
              state_d = S_FLUSH;
              flush_d = 1'b0;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (flush_q) state_d = S_IDLE;
        else         flush_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // col[0] is the oldest row of the current column, col[K-1] the incoming pixel.
  always_comb begin
    for (int r = 0; r < K - 1; r++) col[r] = lb_mem[r][x_q];
    col[K-1] = din;
  end

  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) win_d[r][c] = win_q[r][c];
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = col[r];
      end
    end
  end

  // Pixels are zero-extended to a signed operand before multiplying.
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        prod_d[r*K+c] = PROD_W'($signed({1'b0, win_q[r][c]})) * PROD_W'(coef_q[r*K+c]);
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NC; i++) acc = acc + ACC_W'(prod_q[i]);
    dout_d = dout_q;
    if (v1_q) begin
      if (acc > SAT_MAX)      dout_d = {1'b0, {(OUT_W-1){1'b1}}};
      else if (acc < SAT_MIN) dout_d = {1'b1, {(OUT_W-1){1'b0}}};
      else                    dout_d = acc[OUT_W-1:0];
      if (RELU_EN && dout_d[OUT_W-1]) dout_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      flush_q     <= 1'b0;
      for (int i = 0; i < NC; i++) coef_q[i] <= '0;
      v0_q        <= 1'b0;
      l0_q        <= 1'b0;
      v1_q        <= 1'b0;
      l1_q        <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      flush_q     <= flush_d;
      for (int i = 0; i < NC; i++) coef_q[i] <= coef_d[i];
      v0_q        <= v0_d;
      l0_q        <= l0_d;
      v1_q        <= v0_q;
      l1_q        <= l0_q;
      dout_q      <= dout_d;
      out_valid_q <= v1_q;
      out_last_q  <= l1_q;
    end
  end

  // Datapath storage needs no reset: nothing reaches dout until K-1 rows are loaded.
  always_ff @(posedge clk) begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) win_q[r][c] <= win_d[r][c];
    for (int i = 0; i < NC; i++) prod_q[i] <= prod_d[i];
    if (accept)
      for (int r = 0; r < K - 1; r++) lb_mem[r][x_q] <= col[r+1];
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv2d_stream: scoreboard bench with an arithmetic reference model.     |
// |                                                           Revision: 1.0    |
// +----------------------------------------------------------------------------+
module tb_conv2d_stream;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int K      = 3;
  localparam int OUT_W  = 16;
  localparam int NC     = K * K;
  localparam int AW     = (K > 1) ? $clog2(K * K) : 1;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int MAXV   = (1 << (OUT_W - 1)) - 1;
  localparam int MINV   = -(1 << (OUT_W - 1));

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    coef_wr = 1'b0;
  logic [AW-1:0]           coef_addr = '0;
  logic [COEF_W-1:0]       coef_din = '0;
  logic                    in_st = 1'b0;
  logic                    in_valid = 1'b0;
  logic [DATA_W-1:0]       din = '0;
  logic signed [OUT_W-1:0] dout;
  logic                    out_valid;
  logic                    out_last;
  logic                    busy;

  conv2d_stream #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .IMG_W(IMG_W),
    .IMG_H(IMG_H), .K(K), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coef_wr(coef_wr), .coef_addr(coef_addr),
    .coef_din(coef_din), .in_st(in_st), .in_valid(in_valid), .din(din),
    .dout(dout), .out_valid(out_valid), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     val;
    bit     last;
    longint at;
  } exp_t;

  exp_t sb[$];
  int   coef_m [NC];
  int   pix_m  [NPIX];
  int   checks = 0;
  int   errors = 0;
  bit   reset_req = 1'b0;
  bit   drain_req = 1'b0;
  bit   busy_chk  = 1'b0;

  function automatic int model(input int y, input int x);
    int s = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        s += coef_m[r*K+c] * pix_m[(y - K + 1 + r) * IMG_W + (x - K + 1 + c)];
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Monitor: every comparison and both counters live here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_req) begin
        checks++;
        if (dout !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_state: dout=%0d out_valid=%b out_last=%b busy=%b, required 0/0/0/0",
                   dout, out_valid, out_last, busy);
        end
      end
      if (drain_req) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
      end
      if (busy_chk) begin
        busy_chk = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_after_last: busy=%b, required 0", busy);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_output: dout=%0d at cycle %0d, required no output", dout, cyc);
        end else begin
          e = sb.pop_front();
          if (int'(dout) != e.val || out_last !== e.last || cyc != e.at) begin
            errors++;
            $display("FAIL result: dout=%0d last=%b cycle=%0d, required dout=%0d last=%b cycle=%0d",
                     dout, out_last, cyc, e.val, e.last, e.at);
          end
          if (e.last) busy_chk = 1'b1;
        end
      end else if (rst_n && out_last !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL last_without_valid: out_last=%b, required 0", out_last);
      end
    end
  end

  task automatic load_coefs();
    for (int i = 0; i < NC; i++) begin
      coef_wr   = 1'b1;
      coef_addr = AW'(i);
      coef_din  = COEF_W'(coef_m[i]);
      @(posedge clk); #1;
    end
    coef_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(posedge clk);
      n++;
    end
    #1 drain_req = 1'b1;
    @(negedge clk); #1 drain_req = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // gap: 0 continuous, 1 alternating, 2 random. disturb issues coef_wr/in_st mid-frame.
  task automatic run_frame(input int gap, input bit disturb, input int npix);
    int idx = 0;
    bit tog = 1'b1;
    bit v;
    bit dist_done = 1'b0;
    int y, x;
    exp_t e;
    in_st = 1'b1;
    @(posedge clk); #1;
    in_st = 1'b0;
    while (idx < npix) begin
      case (gap)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = ($urandom_range(3) != 0);
      endcase
      in_valid = v;
      din      = v ? DATA_W'(pix_m[idx]) : DATA_W'($urandom);
      if (disturb && !dist_done && idx == 20) begin
        coef_wr   = 1'b1;
        coef_addr = AW'(NC / 2);
        coef_din  = COEF_W'(100);
        in_st     = 1'b1;
        dist_done = 1'b1;
      end
      if (v) begin
        y = idx / IMG_W;
        x = idx % IMG_W;
        if (y >= K - 1 && x >= K - 1) begin
          e.val  = model(y, x);
          e.last = (idx == NPIX - 1);
          e.at   = cyc + 3;
          sb.push_back(e);
        end
        idx++;
      end
      @(posedge clk); #1;
      coef_wr = 1'b0;
      in_st   = 1'b0;
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic set_coefs(input int v);
    for (int i = 0; i < NC; i++) coef_m[i] = v;
  endtask

  task automatic set_pix(input int mode);
    for (int i = 0; i < NPIX; i++)
      pix_m[i] = (mode == 0) ? (i % (1 << DATA_W)) : (mode == 1) ? 255 : int'($urandom_range(255));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_req = 1'b1;
    @(negedge clk); #1 reset_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_coefs(0); coef_m[NC/2] = 1; set_pix(0); load_coefs();
    run_frame(0, 1'b0, NPIX);

    set_coefs(1); set_pix(1); load_coefs();
    run_frame(0, 1'b0, NPIX);

    set_coefs(127); load_coefs();
    run_frame(0, 1'b0, NPIX);

    set_coefs(-128); load_coefs();
    run_frame(0, 1'b0, NPIX);

    set_coefs(0); coef_m[NC/2] = 1; set_pix(0); load_coefs();
    run_frame(1, 1'b1, NPIX);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NC; i++)
        coef_m[i] = (f == 0) ? int'($urandom_range(255)) - 128 : int'($urandom_range(15)) - 8;
      set_pix(2); load_coefs();
      run_frame(2, 1'b0, NPIX);
    end

    set_coefs(0); coef_m[NC/2] = 1; set_pix(0); load_coefs();
    run_frame(0, 1'b0, 30);
    rst_n = 1'b0;
    reset_req = 1'b1;
    @(negedge clk); #1 reset_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    set_coefs(0); set_pix(2);
    run_frame(2, 1'b0, NPIX);

    for (int i = 0; i < NC; i++) coef_m[i] = int'($urandom_range(31)) - 16;
    set_pix(2); load_coefs();
    run_frame(0, 1'b0, NPIX);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv2d_stream.md
# conv2d_stream

Parametrised streaming 2D convolution engine, the successor to the fixed 8x8 / 3x3 `Conv` block. It accepts a raster-order pixel stream with a valid qualifier and holds K-1 rows in line buffers. Each valid output uses a run-time programmable signed KxK kernel and is produced as a saturated signed result. It sits between the pixel RAM reader and the result collector in the convolution processor.

## Interface
- `DATA_W`, 8: unsigned pixel width.
- `COEF_W`, 8: signed kernel coefficient width.
- `IMG_W`, 8: frame width in pixels (>= K).
- `IMG_H`, 8: frame height in pixels (>= K).
- `K`, 3: kernel size (odd, 1..7).
- `OUT_W`, 16: signed output width.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `coef_wr` input 1: kernel coefficient write strobe.
- `coef_addr` input clog2(K*K): coefficient index, r*K+c, where r=0 is the top (oldest) row and c=0 is the leftmost (oldest) column.
- `coef_din` input COEF_W: signed coefficient.
- `in_st` input 1: frame start pulse.
- `in_valid` input 1: `din` valid this cycle.
- `din` input DATA_W: pixel.
- `dout` output OUT_W: signed convolution result.
- `out_valid` output 1: `dout` valid, one cycle per result.
- `out_last` output 1: final result of the frame, coincident with `out_valid`.
- `busy` output 1: a frame is in progress or draining.

## Operation
- States:
  - IDLE → RUN on `in_st`.
  - RUN → FLUSH after IMG_W*IMG_H pixels have been accepted.
  - FLUSH → IDLE after 2 cycles.
- `busy` = (state != IDLE).
- Pixels are accepted only in RUN with `in_valid`=1. `in_valid` in IDLE or FLUSH is ignored.
- Column and row counters (x, y) advance on each accepted pixel. x wraps at IMG_W-1, at which point y increments.
- Line buffers: K-1 rows of IMG_W x DATA_W. Window register: KxK, shifted on each accepted pixel.
- Result definition (correlation, no kernel flip): the window whose bottom-right pixel is (y,x) is emitted when y>=K-1 and x>=K-1. Value = Σ coef[r*K+c] · pix[y-K+1+r][x-K+1+c].
- Output count: (IMG_W-K+1)*(IMG_H-K+1), which is 36 for the defaults.
- Arithmetic:
  - Products are (DATA_W+1)-bit signed pixel × COEF_W signed.
  - The sum is full precision, DATA_W+COEF_W+1+clog2(K*K) bits.
  - The sum saturates to the OUT_W signed range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Coefficient writes take effect only in IDLE. `coef_wr` while `busy` is ignored, so the kernel is frozen for the whole frame.
- `in_st` while `busy` is ignored.
- Line-buffer contents are never cleared and need not be. No output is emitted until K-1 full rows have been loaded.

## Timing
- Reset values:
  - `dout`=0, `out_valid`=0, `out_last`=0, `busy`=0.
  - State = IDLE, counters = 0.
  - All coefficients = 0.
- Reset asserted mid-frame aborts the frame immediately; the next frame needs a fresh `in_st`.
- `in_st` sampled at edge t puts the block in RUN from t+1. The earliest accepted pixel is at edge t+1.
- Latency is 2 cycles:
  - The window completes on the pixel accepted at edge t.
  - Products are registered at t+1.
  - The saturated sum is registered, and `out_valid` is high, at t+2.
- Gaps in `in_valid` appear as identical gaps in `out_valid`. There is no backpressure.
- `out_last` is high with the result for pixel (IMG_H-1, IMG_W-1). The state is IDLE and `busy`=0 on the following cycle.
- A coefficient write at edge t is used by a frame whose `in_st` is sampled at t+1 or later.

## Configuration
- `CONV_RELU_EN` defined: a stage-2 result that is negative after saturation is output as 0. Latency is unchanged.
- `CONV_RELU_EN` undefined: signed saturated results pass through unchanged.

## Test plan
- Identity kernel, ramp frame:
  - Stimulus: coef[4]=1, others 0; 8x8 frame with pixel = index 0..63, continuous valid.
  - Response: 36 outputs, first 9, last 54, `out_last` on the 36th.
  - Timing: first `out_valid` 2 cycles after pixel 18 is accepted.
- Averaging sum: all coefs=1, all pixels 255 → every output 2295.
- Positive saturation: all coefs=127, pixels 255 (sum 291465) → every output 32767.
- Negative saturation: all coefs=-128, pixels 255 → every output -32768 without `CONV_RELU_EN`, 0 with it.
- Gapped input and ignored writes:
  - Stimulus: ramp frame with `in_valid` toggling 1,0,1,0; a `coef_wr` and an `in_st` issued mid-frame.
  - Response: same 36 values as the identity test, `out_valid` spaced 2 cycles apart, kernel unchanged.
- Reset mid-frame:
  - Stimulus: `rst_n` low after 30 pixels.
  - Response: all outputs 0, `busy`=0, coefs 0.
  - Follow-up: reprogramming the kernel and sending a new frame gives the correct 36 results.
